// File: rtl/traffic_light_pkg.sv
// Shared types and defaults for the three-aspect traffic-light controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } light_state_t;

  localparam int DEF_RED_CYCLES    = 32;
  localparam int DEF_GREEN_CYCLES  = 20;
  localparam int DEF_YELLOW_CYCLES = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_light_dwell_counter.sv
// Enabled up-counter with synchronous clear and terminal-count compare
// against a limit supplied at run time by the owning FSM.
module dwell_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Clear wins over increment so a transition edge always restarts at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/traffic_light.sv
// Cyclic RED -> GREEN -> YELLOW controller; each aspect dwells for a
// parameterised number of enabled clocks, lamps are registered one-hot.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = $clog2(max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RED_LIM    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_CYCLES - 1);

  if (RED_CYCLES < 1) begin : g_bad_red
    $error("traffic_light: RED_CYCLES must be >= 1");
  end
  if (GREEN_CYCLES < 1) begin : g_bad_green
    $error("traffic_light: GREEN_CYCLES must be >= 1");
  end
  if (YELLOW_CYCLES < 1) begin : g_bad_yellow
    $error("traffic_light: YELLOW_CYCLES must be >= 1");
  end

  light_state_t     r_state;
  light_state_t     w_state_d;
  logic [CNT_W-1:0] w_limit;
  logic             w_tc;
  logic             w_advance;
  logic             w_illegal;
  logic             r_red;
  logic             r_yellow;
  logic             r_green;

  always_comb begin
    w_limit   = '0;
    w_illegal = 1'b0;
    case (r_state)
      ST_RED:    w_limit = RED_LIM;
      ST_GREEN:  w_limit = GREEN_LIM;
      ST_YELLOW: w_limit = YELLOW_LIM;
      default:   w_illegal = 1'b1;
    endcase
  end

  assign w_advance = enable && w_tc && !w_illegal;

  dwell_counter #(.W(CNT_W)) u_dwell (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (enable),
    .i_clr   (w_advance || w_illegal),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Next state is computed once and feeds both the state and lamp registers,
  // so lamps change on the very edge that decides a transition.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_RED:    if (w_advance) w_state_d = ST_GREEN;
      ST_GREEN:  if (w_advance) w_state_d = ST_YELLOW;
      ST_YELLOW: if (w_advance) w_state_d = ST_RED;
      default:   w_state_d = ST_RED;
    endcase
    if (reset) w_state_d = ST_RED;
  end

  always_ff @(posedge clk) begin
    r_state  <= w_state_d;
    r_red    <= (w_state_d == ST_RED);
    r_yellow <= (w_state_d == ST_YELLOW);
    r_green  <= (w_state_d == ST_GREEN);
  end

  assign red       = r_red;
  assign yellow    = r_yellow;
  assign green     = r_green;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: default-parameter instance plus a 1/1/1 instance,
// checked against a position-in-cycle reference model.
module tb_traffic_light;

  localparam int R_CYC = 32;
  localparam int G_CYC = 20;
  localparam int Y_CYC = 7;
  localparam int TOTAL = R_CYC + G_CYC + Y_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       red, yellow, green;
  logic [1:0] dbg_state;

  logic       reset2 = 1'b1;
  logic       enable2 = 1'b0;
  logic       red2, yellow2, green2;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;

  // Model: position = enabled edges since reset, modulo the full cycle.
  int pos  = 0;
  int pos2 = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  always #5 clk = ~clk;

  traffic_light dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .red       (red),
    .yellow    (yellow),
    .green     (green),
    .dbg_state (dbg_state)
  );

  traffic_light #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1)
  ) dut_min (
    .clk       (clk),
    .reset     (reset2),
    .enable    (enable2),
    .red       (red2),
    .yellow    (yellow2),
    .green     (green2),
    .dbg_state (dbg_state2)
  );

  // Expected {red, yellow, green} for a position inside a cycle of r/g/y dwells.
  function automatic logic [2:0] lamps_at(input int p, input int r, input int g);
    if (p < r)          return 3'b100;
    else if (p < r + g) return 3'b001;
    else                return 3'b010;
  endfunction

  task automatic step(input logic rst, input logic en);
    @(negedge clk);
    reset  = rst;
    enable = en;
    @(posedge clk);
    if (rst)     pos = 0;
    else if (en) pos = (pos + 1) % TOTAL;
    exp_q.push_back(lamps_at(pos, R_CYC, G_CYC));
    #1;
  endtask

  task automatic step2(input logic rst, input logic en);
    @(negedge clk);
    reset2  = rst;
    enable2 = en;
    @(posedge clk);
    if (rst)     pos2 = 0;
    else if (en) pos2 = (pos2 + 1) % 3;
    exp_q.push_back(lamps_at(pos2, 1, 1));
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {red, yellow, green}, exp_v);
      end
    end
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, {red, yellow, green}, exp_v);
      end
    end
  endtask

  task automatic test_nominal();
    int edges;
    int g_at;
    g_at  = -1;
    edges = 0;
    step(1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < TOTAL; i++) begin
      step(1'b0, 1'b1);
      edges++;
      exp_v = exp_q.pop_front();
      if (green === 1'b1 && g_at < 0) g_at = edges;
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL nominal edge=%0d got=%b exp=%b", edges, {red, yellow, green}, exp_v);
      end
    end
    checks++;
    if (g_at !== R_CYC) begin
      errors++;
      $display("FAIL nominal_green_edge got=%0d exp=%0d", g_at, R_CYC);
    end
  endtask

  task automatic test_wrap();
    int rises;
    logic prev_g;
    rises  = 0;
    prev_g = 1'b0;
    step(1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4 * TOTAL; i++) begin
      step(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      if (green === 1'b1 && prev_g === 1'b0) rises++;
      prev_g = green;
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL wrap edge=%0d got=%b exp=%b", i + 1, {red, yellow, green}, exp_v);
      end
    end
    checks++;
    if (rises !== 4) begin
      errors++;
      $display("FAIL wrap_green_rises got=%0d exp=4", rises);
    end
  endtask

  task automatic test_pause();
    int n;
    step(1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < R_CYC + 5; i++) begin
      step(1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL pause_frozen cyc=%0d got=%b exp=%b", i, {red, yellow, green}, exp_v);
      end
    end
    n = 0;
    while (yellow !== 1'b1 && n < 100) begin
      step(1'b0, 1'b1);
      void'(exp_q.pop_front());
      n++;
    end
    checks++;
    if (n !== G_CYC - 5) begin
      errors++;
      $display("FAIL pause_resume_edges got=%0d exp=%0d", n, G_CYC - 5);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    step(1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < R_CYC + G_CYC + 3; i++) begin
      step(1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
    checks++;
    if (yellow !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre got=%b exp=1", yellow);
    end
    step(1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if ({red, yellow, green} !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_edge got=%b exp=%b", {red, yellow, green}, exp_v);
    end
    n = 0;
    while (green !== 1'b1 && n < 100) begin
      step(1'b0, 1'b1);
      void'(exp_q.pop_front());
      n++;
    end
    checks++;
    if (n !== R_CYC) begin
      errors++;
      $display("FAIL mid_reset_green_edges got=%0d exp=%0d", n, R_CYC);
    end
  endtask

  task automatic test_random();
    logic rst;
    logic en;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 3) != 0);
      step(rst, en);
      exp_v = exp_q.pop_front();
      checks++;
      if ({red, yellow, green} !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d rst=%b en=%b got=%b exp=%b",
                 i, rst, en, {red, yellow, green}, exp_v);
      end
    end
  endtask

  task automatic test_min_params();
    step2(1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 12; i++) begin
      step2(1'b0, ($urandom_range(0, 4) != 0));
      exp_v = exp_q.pop_front();
      checks++;
      if ({red2, yellow2, green2} !== exp_v) begin
        errors++;
        $display("FAIL min_params cyc=%0d got=%b exp=%b", i, {red2, yellow2, green2}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_pause();
    test_mid_reset();
    test_random();
    test_min_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
# traffic_light

Cyclic three-aspect traffic-light controller. Sequences RED → GREEN → YELLOW → RED, and holds each aspect for a parameterised number of enabled clock cycles. Outputs are registered, one-hot lamp drives. It is a leaf block used by intersection-control logic, which gates progress through the `enable` input.

## Interface
- `RED_CYCLES`, default 32: enabled cycles spent in RED; must be ≥ 1.
- `GREEN_CYCLES`, default 20: enabled cycles spent in GREEN; must be ≥ 1.
- `YELLOW_CYCLES`, default 7: enabled cycles spent in YELLOW; must be ≥ 1.
- `clk`, input, 1: the only clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: advance permission. When low, the state and the dwell counter are frozen.
- `red`, output, 1: red lamp, registered.
- `yellow`, output, 1: yellow lamp, registered.
- `green`, output, 1: green lamp, registered.

## Operation
- States are RED, GREEN and YELLOW. Exactly one lamp output is high at all times, including during and after reset.
- A dwell counter counts enabled cycles in the current state.
  - Width is `$clog2(max(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)) + 1`.
  - It is cleared on every state change.
- The counter increments only on clocks where `enable` = 1.
- Transition rules, on an enabled clock:
  - RED → GREEN when the counter equals `RED_CYCLES` − 1.
  - GREEN → YELLOW when the counter equals `GREEN_CYCLES` − 1.
  - YELLOW → RED when the counter equals `YELLOW_CYCLES` − 1.
- The counter is cleared on the same edge as the transition.
- With `enable` = 0, state, counter and outputs hold their values indefinitely. Toggling `enable` pauses the dwell and then resumes it without restarting it.
- Unreachable or illegal state encodings recover to RED with the counter cleared on the next clock.
- If any parameter is < 1, a simulation-time `$error` is raised at elaboration.

## Timing
- Reset: while `reset` = 1 at a rising edge, the next values are state = RED and counter = 0. Outputs become `red`=1, `yellow`=0, `green`=0. Reset has priority over `enable`.
- Reset mid-operation, in any state at any count, gives RED/0 on that edge. The full RED dwell then restarts.
- Outputs are decoded from registered state with no combinational path from `enable` to the lamps. A transition is therefore visible immediately after the clock edge on which it was decided.
- Reset release with `enable` = 1: the first edge after release is counted as RED cycle 1. GREEN appears after exactly `RED_CYCLES` enabled edges.
- Full cycle length is `RED_CYCLES` + `GREEN_CYCLES` + `YELLOW_CYCLES` enabled edges (59 with defaults). Cycles are back-to-back and wrap with no idle state.
- `enable` is sampled on each rising edge. A deassertion on the terminal-count edge blocks that transition until `enable` is high on a later edge.

## Structure
- Shared package `traffic_light_pkg`:
  - enum `light_state_t` with values `{ST_RED, ST_GREEN, ST_YELLOW}`, 2-bit encoding.
  - default-duration constants.
- Sub-module `dwell_counter`: up-counter with enable, synchronous clear, and terminal-count compare against a runtime limit input. The top level selects the limit by current state.
- Top level contains the state register, next-state logic, lamp decode and parameter assertions.

## Test plan
- Reset hold: hold `reset` high for 3 clocks with `enable` = 1, then release and hold `enable` = 0 for 50 clocks → `red`=1, `yellow`=0, `green`=0 throughout.
- Nominal sequence: from reset, `enable` = 1 → `green` rises after exactly 32 edges, `yellow` after 20 more, `red` after 7 more. The lamps are one-hot on every cycle.
- Wrap-around: run 4 full cycles (236 enabled edges) → the transitions repeat at offsets 32/52/59 modulo 59 with no drift.
- Pause: drop `enable` for 10 clocks at GREEN count 5 → lamps are frozen. After re-enable, YELLOW appears after 15 further enabled edges.
- Mid-operation reset: pulse `reset` for 1 clock in YELLOW at count 3 → RED on that edge. GREEN then follows after 32 enabled edges.
- Parameter override with `RED_CYCLES`=1, `GREEN_CYCLES`=1, `YELLOW_CYCLES`=1 and `enable` = 1 → the aspect changes on every edge: R, G, Y, R, …
